pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
//  - Drives enable and flush for the PC and each pipeline latch.
//  - Sources: load-use hazards, imem/dmem wait handshakes, multi-cycle mul/div busy, taken branches, halt.
//  - Companion to forward_unit: forwarding covers ALU->ALU hazards; this block covers what forwarding cannot.
// PARAMETERS
//  CNT_W  32  width of the stall_cycles performance counter (saturates, never wraps)
// PORTS
//  clk            in   1      core clock
//  rst            in   1      asynchronous reset, active-high
//  id_rsel1       in   reg_t  rs1 of the instruction in ID
//  id_rsel2       in   reg_t  rs2 of the instruction in ID
//  ex_rd          in   reg_t  rd of the instruction in EX
//  ex_mem_read    in   1      EX instruction is a load
//  ex_branch_tkn  in   1      EX resolved a taken branch/jump (redirect)
//  ex_muldiv_start in  1      EX issues a multi-cycle mul/div this cycle
//  muldiv_done    in   1      mul/div result valid (1-cycle pulse)
//  imem_ready     in   1      instruction fetch completes this cycle
//  mem_dreq       in   1      MEM stage has a data access pending
//  dmem_ready     in   1      data access completes this cycle
//  wb_halt        in   1      halt instruction reached WB
//  pc_en, ifid_en, idex_en, exmem_en, memwb_en             out 1  latch enables
//  ifid_flush, idex_flush, exmem_flush, memwb_flush        out 1  insert bubble (NOP) at next edge
//  halted         out  1      core halted
//  stall_cycles   out  CNT_W  count of cycles with pc_en==0 and state!=HALT
// BEHAVIOUR
//  - Reset values:
//    - state=RUN, stall_cycles=0, halted=0.
//    - Outputs are combinational from state+inputs; with idle inputs: all *_en=1, all *_flush=0.
//  - Definitions:
//    - freeze(X) = X_en=0, X_flush=0.
//    - bubble(X) = X_flush=1; flush wins over en inside the latch.
//  - States: RUN, DWAIT, MWAIT, HALT (ctrl_state_t).
//  - RUN evaluates events in priority order; only the highest active event acts:
//    1. wb_halt: freeze all, next=HALT.
//    2. mem_dreq && !dmem_ready: freeze pc/ifid/idex/exmem, bubble memwb, next=DWAIT.
//    3. ex_muldiv_start && !muldiv_done: freeze pc/ifid/idex, bubble exmem, next=MWAIT.
//    4. ex_branch_tkn: pc_en=1 (loads target), bubble ifid+idex; exactly one cycle.
//    5. Load-use, i.e. ex_mem_read && ex_rd!=0 && (ex_rd==id_rsel1 || ex_rd==id_rsel2):
//       freeze pc/ifid, bubble idex; one cycle.
//    6. !imem_ready: freeze pc/ifid, bubble idex.
//  - DWAIT:
//    - Outputs as in event 2 until dmem_ready=1.
//    - On the dmem_ready cycle: all en=1, no flush, next=RUN.
//    - wb_halt is ignored in DWAIT, because the WB slot holds a bubble.
//  - MWAIT:
//    - Outputs as in event 3 until muldiv_done=1.
//    - On the muldiv_done cycle: en=1, no flush, next=RUN.
//    - A mem_dreq in the same cycle is handled by RUN next cycle.
//  - HALT:
//    - All en=0, flush=0, halted=1.
//    - Sticky until rst.
//  - A branch masked by DWAIT/MWAIT is not lost: EX is frozen, so ex_branch_tkn re-presents on exit.
//  - Same-cycle dreq/dready or start/done pulse: zero stall cycles, state stays RUN.
//  - stall_cycles:
//    - +1 on each edge where pc_en==0 and state!=HALT (the halt-entry cycle counts).
//    - Saturates at all-ones.
//  - rst asserted mid-DWAIT/MWAIT: immediate return to RUN and counter=0; no pending event is remembered.
//  - Load-use with ex_rd==0 never stalls.
//  - Latency: all control outputs are same-cycle combinational; only state and counter are registered.
// STRUCTURE
//  - common_types_pkg gains:
//    - typedef enum logic [1:0] {RUN,DWAIT,MWAIT,HALT} ctrl_state_t
//    - struct stage_ctrl_t {logic en; logic flush;}
//  - New interface pipeline_ctrl_if:
//    - modport pipeline_ctrl (inputs/outputs as above).
//    - modport tb (mirror).
//  - Sub-module hazard_detect (combinational load-use compare) is natural; everything else is flat.
// TESTING
//  - Load-use: ex_mem_read=1, ex_rd=5, id_rsel2=5
//    -> 1 cycle pc_en=ifid_en=0, idex_flush=1; stall_cycles=1.
//  - Same as above with ex_rd=0 -> no stall; all en=1.
//  - dmem wait: mem_dreq=1, dmem_ready low 3 cycles then high
//    -> 3 cycles exmem_en=0, memwb_flush=1, state DWAIT; 4th cycle all en=1, RUN; counter=3.
//  - Branch during MWAIT: start muldiv with ex_branch_tkn=1, done after 4 cycles
//    -> no ifid/idex flush during MWAIT; flush of ifid+idex on the first cycle after return to RUN.
//  - Halt: wb_halt=1 -> halted=1 next cycle, all en=0;
//    stays halted despite imem/dmem activity until rst.
//  - rst pulse during DWAIT -> state RUN, stall_cycles=0, all en=1 with idle inputs.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    MWAIT = 2'd2,
    HALT  = 2'd3
  } ctrl_state_t;

  // Control pair for one pipeline latch; flush overrides en inside the latch.
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_PASS   = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_FREEZE = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of the sequencer's signals, for integration and bench use.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  import pipeline_ctrl_pkg::*;

  reg_t             id_rsel1;
  reg_t             id_rsel2;
  reg_t             ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_tkn;
  logic             ex_muldiv_start;
  logic             muldiv_done;
  logic             imem_ready;
  logic             mem_dreq;
  logic             dmem_ready;
  logic             wb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  ctrl_state_t      dbg_state;

  modport pipeline_ctrl (
    input  id_rsel1, id_rsel2, ex_rd, ex_mem_read, ex_branch_tkn,
           ex_muldiv_start, muldiv_done, imem_ready, mem_dreq, dmem_ready, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles, dbg_state
  );

  modport tb (
    output id_rsel1, id_rsel2, ex_rd, ex_mem_read, ex_branch_tkn,
           ex_muldiv_start, muldiv_done, imem_ready, mem_dreq, dmem_ready, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles, dbg_state
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the ID instruction.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic ex_mem_read,
  input  reg_t ex_rd,
  input  reg_t id_rsel1,
  input  reg_t id_rsel2,
  output logic load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((ex_rd == id_rsel1) || (ex_rd == id_rsel2));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Control outputs are combinational
// from state and inputs; only the state and the stall counter are registered.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_t             id_rsel1,
  input  reg_t             id_rsel2,
  input  reg_t             ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_tkn,
  input  logic             ex_muldiv_start,
  input  logic             muldiv_done,
  input  logic             imem_ready,
  input  logic             mem_dreq,
  input  logic             dmem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output ctrl_state_t      dbg_state
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  stage_ctrl_t ifid, idex, exmem, memwb;
  logic        load_use;

  pipeline_ctrl_hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rsel1    (id_rsel1),
    .id_rsel2    (id_rsel2),
    .load_use    (load_use)
  );

  // Per-state control decode; in RUN only the highest-priority event acts.
  always_comb begin
    pc_en     = 1'b1;
    ifid      = STAGE_PASS;
    idex      = STAGE_PASS;
    exmem     = STAGE_PASS;
    memwb     = STAGE_PASS;
    state_nxt = state;
    case (state)
      RUN: begin
        if (wb_halt) begin
          pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_FREEZE;
          exmem = STAGE_FREEZE; memwb = STAGE_FREEZE;
          state_nxt = HALT;
        end else if (mem_dreq && !dmem_ready) begin
          pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_FREEZE;
          exmem = STAGE_FREEZE; memwb = STAGE_BUBBLE;
          state_nxt = DWAIT;
        end else if (ex_muldiv_start && !muldiv_done) begin
          pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_FREEZE;
          exmem = STAGE_BUBBLE;
          state_nxt = MWAIT;
        end else if (ex_branch_tkn) begin
          ifid = STAGE_BUBBLE; idex = STAGE_BUBBLE;
        end else if (load_use || !imem_ready) begin
          pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_BUBBLE;
        end
      end
      // WB holds a bubble here, so wb_halt cannot be genuine and is ignored.
      DWAIT: begin
        if (!dmem_ready) begin
          pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_FREEZE;
          exmem = STAGE_FREEZE; memwb = STAGE_BUBBLE;
        end else begin
          state_nxt = RUN;
        end
      end
      MWAIT: begin
        if (!muldiv_done) begin
          pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_FREEZE;
          exmem = STAGE_BUBBLE;
        end else begin
          state_nxt = RUN;
        end
      end
      HALT: begin
        pc_en = 1'b0; ifid = STAGE_FREEZE; idex = STAGE_FREEZE;
        exmem = STAGE_FREEZE; memwb = STAGE_FREEZE;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign ifid_en     = ifid.en;
  assign ifid_flush  = ifid.flush;
  assign idex_en     = idex.en;
  assign idex_flush  = idex.flush;
  assign exmem_en    = exmem.en;
  assign exmem_flush = exmem.flush;
  assign memwb_en    = memwb.en;
  assign memwb_flush = memwb.flush;
  assign halted      = (state == HALT);
  assign dbg_state   = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Saturating count of stalled cycles outside HALT (halt entry counts).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_en && (state != HALT) && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized run against a
// behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  reg_t          id_rsel1, id_rsel2, ex_rd;
  logic          ex_mem_read, ex_branch_tkn, ex_muldiv_start, muldiv_done;
  logic          imem_ready, mem_dreq, dmem_ready, wb_halt;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic          halted;
  logic [CW-1:0] stall_cycles;
  ctrl_state_t   dbg_state;

  int checks = 0;
  int failures = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_tkn(ex_branch_tkn),
    .ex_muldiv_start(ex_muldiv_start), .muldiv_done(muldiv_done),
    .imem_ready(imem_ready), .mem_dreq(mem_dreq), .dmem_ready(dmem_ready),
    .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush),
    .halted(halted), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Observed enables/flushes, index 0 = PC .. 4 = MEM/WB (PC has no flush).
  wire [4:0] got_en = {memwb_en, exmem_en, idex_en, ifid_en, pc_en};
  wire [4:0] got_fl = {memwb_flush, exmem_flush, idex_flush, ifid_flush, 1'b0};

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_rsel1 = '0; id_rsel2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_branch_tkn = 1'b0; ex_muldiv_start = 1'b0;
    muldiv_done = 1'b0; imem_ready = 1'b1; mem_dreq = 1'b0; dmem_ready = 1'b0;
    wb_halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_DWAIT = 1, M_MWAIT = 2, M_HALT = 3;
  int            m_mode;
  logic [CW-1:0] m_cnt;

  // Expected outputs: the active action freezes the first n_freeze stages
  // (counted from the PC) and inserts bubbles into the stages in bub.
  function automatic void model_eval(input int mode, output logic [4:0] en,
                                     output logic [4:0] fl, output int nxt);
    int        n_freeze;
    logic [4:0] bub;
    logic      lu;
    lu = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rsel1 || ex_rd == id_rsel2);
    n_freeze = 0; bub = 5'b00000; nxt = mode;
    if (mode == M_HALT) begin
      n_freeze = 5;
    end else if (mode == M_DWAIT) begin
      if (dmem_ready) nxt = M_RUN;
      else begin n_freeze = 4; bub = 5'b10000; end
    end else if (mode == M_MWAIT) begin
      if (muldiv_done) nxt = M_RUN;
      else begin n_freeze = 3; bub = 5'b01000; end
    end else begin
      if (wb_halt) begin n_freeze = 5; nxt = M_HALT; end
      else if (mem_dreq && !dmem_ready) begin n_freeze = 4; bub = 5'b10000; nxt = M_DWAIT; end
      else if (ex_muldiv_start && !muldiv_done) begin n_freeze = 3; bub = 5'b01000; nxt = M_MWAIT; end
      else if (ex_branch_tkn) bub = 5'b00110;
      else if (lu || !imem_ready) begin n_freeze = 2; bub = 5'b00100; end
    end
    for (int i = 0; i < 5; i++) en[i] = (i >= n_freeze);
    fl = bub;
  endfunction

  function automatic ctrl_state_t mode_state(input int mode);
    case (mode)
      M_DWAIT: return DWAIT;
      M_MWAIT: return MWAIT;
      M_HALT:  return HALT;
      default: return RUN;
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({got_en, got_fl, halted, dbg_state} !== {5'b11111, 5'b00000, 1'b0, RUN}) begin
      failures++;
      $display("FAIL reset_outputs: en=%b fl=%b halted=%b state=%0d, want en=11111 fl=00000 halted=0 state=0",
               got_en, got_fl, halted, dbg_state);
    end
    checks++;
    if (stall_cycles !== 0) begin
      failures++;
      $display("FAIL reset_counter: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rsel1 = 5'd3; id_rsel2 = 5'd5;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush, idex_en} !== 4'b0011) begin
      failures++;
      $display("FAIL load_use_stall: pc_en=%b ifid_en=%b idex_flush=%b idex_en=%b want 0 0 1 1",
               pc_en, ifid_en, idex_flush, idex_en);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (stall_cycles !== 1 || dbg_state !== RUN || got_en !== 5'b11111) begin
      failures++;
      $display("FAIL load_use_after: cnt=%0d state=%0d en=%b want cnt=1 state=0 en=11111",
               stall_cycles, dbg_state, got_en);
    end
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rsel1 = 5'd0; id_rsel2 = 5'd0;
    #1;
    checks++;
    if (got_en !== 5'b11111 || got_fl !== 5'b00000) begin
      failures++;
      $display("FAIL load_use_x0: en=%b fl=%b want en=11111 fl=00000", got_en, got_fl);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (stall_cycles !== 1) begin
      failures++;
      $display("FAIL load_use_x0_cnt: got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    mem_dreq = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (exmem_en !== 1'b0 || memwb_flush !== 1'b1 || pc_en !== 1'b0) begin
        failures++;
        $display("FAIL dwait_stall[%0d]: exmem_en=%b memwb_flush=%b pc_en=%b want 0 1 0",
                 c, exmem_en, memwb_flush, pc_en);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dbg_state !== DWAIT) begin
        failures++;
        $display("FAIL dwait_state[%0d]: got %0d want %0d", c, dbg_state, DWAIT);
      end
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (got_en !== 5'b11111 || got_fl !== 5'b00000) begin
      failures++;
      $display("FAIL dwait_release: en=%b fl=%b want en=11111 fl=00000", got_en, got_fl);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (dbg_state !== RUN || stall_cycles !== 3) begin
      failures++;
      $display("FAIL dwait_exit: state=%0d cnt=%0d want state=0 cnt=3", dbg_state, stall_cycles);
    end
  endtask

  task automatic test_branch_mwait();
    do_reset();
    ex_muldiv_start = 1'b1; ex_branch_tkn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ifid_flush !== 1'b0 || idex_flush !== 1'b0 || exmem_flush !== 1'b1 || pc_en !== 1'b0) begin
        failures++;
        $display("FAIL mwait_mask[%0d]: ifid_flush=%b idex_flush=%b exmem_flush=%b pc_en=%b want 0 0 1 0",
                 c, ifid_flush, idex_flush, exmem_flush, pc_en);
      end
      @(negedge clk);
      ex_muldiv_start = 1'b0;
    end
    muldiv_done = 1'b1;
    #1;
    checks++;
    if (dbg_state !== MWAIT || got_en !== 5'b11111 || got_fl !== 5'b00000) begin
      failures++;
      $display("FAIL mwait_done: state=%0d en=%b fl=%b want state=2 en=11111 fl=00000",
               dbg_state, got_en, got_fl);
    end
    @(negedge clk);
    muldiv_done = 1'b0;
    #1;
    checks++;
    if (dbg_state !== RUN || got_fl !== 5'b00110 || pc_en !== 1'b1) begin
      failures++;
      $display("FAIL mwait_branch_replay: state=%0d fl=%b pc_en=%b want state=0 fl=00110 pc_en=1",
               dbg_state, got_fl, pc_en);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (stall_cycles !== 4) begin
      failures++;
      $display("FAIL mwait_cnt: got %0d want 4", stall_cycles);
    end
  endtask

  task automatic test_halt();
    do_reset();
    wb_halt = 1'b1;
    #1;
    checks++;
    if (got_en !== 5'b00000 || got_fl !== 5'b00000 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_entry: en=%b fl=%b halted=%b want 00000 00000 0", got_en, got_fl, halted);
    end
    @(negedge clk);
    wb_halt = 1'b0;
    for (int c = 0; c < 6; c++) begin
      imem_ready = 1'($urandom_range(0, 1));
      mem_dreq = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      ex_branch_tkn = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (halted !== 1'b1 || got_en !== 5'b00000 || got_fl !== 5'b00000 || stall_cycles !== 1) begin
        failures++;
        $display("FAIL halt_sticky[%0d]: halted=%b en=%b fl=%b cnt=%0d want 1 00000 00000 1",
                 c, halted, got_en, got_fl, stall_cycles);
      end
      @(negedge clk);
    end
    do_reset();
    #1;
    checks++;
    if (halted !== 1'b0 || dbg_state !== RUN) begin
      failures++;
      $display("FAIL halt_cleared: halted=%b state=%0d want 0 0", halted, dbg_state);
    end
  endtask

  task automatic test_rst_dwait();
    do_reset();
    mem_dreq = 1'b1; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== DWAIT || stall_cycles !== 2) begin
      failures++;
      $display("FAIL rst_dwait_pre: state=%0d cnt=%0d want 1 2", dbg_state, stall_cycles);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dbg_state !== RUN || stall_cycles !== 0) begin
      failures++;
      $display("FAIL rst_dwait_clear: state=%0d cnt=%0d want 0 0", dbg_state, stall_cycles);
    end
    rst = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (got_en !== 5'b11111 || got_fl !== 5'b00000) begin
      failures++;
      $display("FAIL rst_dwait_idle: en=%b fl=%b want 11111 00000", got_en, got_fl);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 1'b0;
    repeat ((1 << CW) + 5) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== {CW{1'b1}}) begin
      failures++;
      $display("FAIL cnt_saturate: got %0d want %0d", stall_cycles, (1 << CW) - 1);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [4:0] e_en, e_fl;
    int         nxt;
    int         halt_age;
    do_reset();
    m_mode = M_RUN; m_cnt = '0; halt_age = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ((m_mode == M_HALT && halt_age > 3) || $urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        m_mode = M_RUN; m_cnt = '0; halt_age = 0;
        rst = 1'b0;
      end
      id_rsel1 = 5'($urandom_range(0, 7));
      id_rsel2 = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch_tkn = ($urandom_range(0, 3) == 0);
      ex_muldiv_start = ($urandom_range(0, 7) == 0);
      muldiv_done = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      mem_dreq = ($urandom_range(0, 5) == 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      wb_halt = ($urandom_range(0, 79) == 0);
      #1;
      model_eval(m_mode, e_en, e_fl, nxt);
      checks++;
      if ({got_en, got_fl, halted, dbg_state} !==
          {e_en, e_fl, (m_mode == M_HALT), mode_state(m_mode)}) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: en=%b fl=%b halted=%b state=%0d want en=%b fl=%b halted=%b state=%0d",
                 c, got_en, got_fl, halted, dbg_state, e_en, e_fl, (m_mode == M_HALT),
                 mode_state(m_mode));
      end
      checks++;
      if (stall_cycles !== m_cnt) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, stall_cycles, m_cnt);
      end
      @(posedge clk);
      if (!e_en[0] && m_mode != M_HALT && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (m_mode == M_HALT) halt_age++;
      m_mode = nxt;
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_branch_mwait();
    test_halt();
    test_rst_dwait();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
